// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: per-register Normal/Flush/Stall codes,
// memory-wait FSM with timeout watchdog, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_jump,
  input  logic             EX_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       hazard_PC,
  output logic [1:0]       hazard_IF_ID,
  output logic [1:0]       hazard_ID_EX,
  output logic [1:0]       hazard_EX_MEM,
  output logic [1:0]       hazard_MEM_WB,
  output logic [CNT_W-1:0] stall_count,
  output logic             timeout_err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] CodeNormal = 2'b00;
  localparam logic [1:0] CodeFlush  = 2'b01;
  localparam logic [1:0] CodeStall  = 2'b10;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StError   = 2'b10
  } state_e;

  state_e           r_state;
  logic [WaitW-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_stall_count;
  logic             r_timeout_err;

  logic w_load_use;
  logic w_mem_miss;
  logic w_wait_limit;

  // Codes from the branch / jump / load-use priority chain, shared by RUN and MEM_WAIT completion.
  logic [1:0] w_pri_pc;
  logic [1:0] w_pri_if_id;
  logic [1:0] w_pri_id_ex;
  logic       w_mem_hold;

  // Register $0 is hardwired, so a load targeting it never creates a dependency.
  assign w_load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == ID_rs) || (ID_uses_rt && (ID_EX_rd == ID_rt)));

  assign w_mem_miss   = mem_req && !mem_ready;
  assign w_wait_limit = (r_wait_cnt == WaitW'(TIMEOUT - 1));

  always_comb begin
    w_pri_pc    = CodeNormal;
    w_pri_if_id = CodeNormal;
    w_pri_id_ex = CodeNormal;
    if (EX_branch_taken) begin
      w_pri_if_id = CodeFlush;
      w_pri_id_ex = CodeFlush;
    end else if (ID_jump) begin
      w_pri_if_id = CodeFlush;
    end else if (w_load_use) begin
      w_pri_pc    = CodeStall;
      w_pri_if_id = CodeStall;
      w_pri_id_ex = CodeFlush;
    end
  end

  always_comb begin
    w_mem_hold = 1'b0;
    unique case (r_state)
      StRun:     w_mem_hold = w_mem_miss;
      StMemWait: w_mem_hold = !mem_ready;
      StError:   w_mem_hold = 1'b1;
      default:   w_mem_hold = 1'b0;
    endcase
  end

  always_comb begin
    hazard_PC     = CodeNormal;
    hazard_IF_ID  = CodeNormal;
    hazard_ID_EX  = CodeNormal;
    hazard_EX_MEM = CodeNormal;
    hazard_MEM_WB = CodeNormal;
    if (!reset) begin
      if (w_mem_hold) begin
        // Freeze everything up to MEM and send a bubble into WB.
        hazard_PC     = CodeStall;
        hazard_IF_ID  = CodeStall;
        hazard_ID_EX  = CodeStall;
        hazard_EX_MEM = CodeStall;
        hazard_MEM_WB = CodeFlush;
      end else begin
        hazard_PC    = w_pri_pc;
        hazard_IF_ID = w_pri_if_id;
        hazard_ID_EX = w_pri_id_ex;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StRun;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_mem_miss) begin
            r_state    <= StMemWait;
            r_wait_cnt <= WaitW'(1);
          end
        end
        StMemWait: begin
          // A completing access wins over the watchdog on the same edge.
          if (mem_ready) begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
          end else if (w_wait_limit) begin
            r_state       <= StError;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WaitW'(1);
          end
        end
        StError: begin
          r_timeout_err <= 1'b1;
        end
        default: begin
          r_state    <= StRun;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if ((hazard_PC == CodeStall) && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;
  assign timeout_err = r_timeout_err;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline.
- Each cycle it drives the 2-bit hazard code of every pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) from four hazard sources: load-use, taken branch in EX, jump in ID, and multi-cycle data-memory access.
- Contains a small FSM for memory waits, a wait-timeout watchdog, and a saturating stall-cycle counter.

Parameters:
- TIMEOUT, 256: maximum consecutive MEM_WAIT cycles before the error trap (≥2).
- CNT_W, 16: width of the stall_count statistic.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_uses_rt  in  1  instruction in ID reads rt.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_rd  in  5  destination register of the instruction in EX.
- ID_jump  in  1  jump resolved in ID this cycle.
- EX_branch_taken  in  1  branch in EX resolved taken this cycle.
- mem_req  in  1  MEM stage issues a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- hazard_PC  out  2  PC register code.
- hazard_IF_ID  out  2  IF_ID register code.
- hazard_ID_EX  out  2  ID_EX register code.
- hazard_EX_MEM  out  2  EX_MEM register code.
- hazard_MEM_WB  out  2  MEM_WB register code.
- stall_count  out  CNT_W  cycles in which hazard_PC==Stall, saturating.
- timeout_err  out  1  sticky memory-timeout flag.

Behaviour:
- Code encoding: Normal=2'b00, Flush=2'b01, Stall=2'b10. 2'b11 is never driven. PC register accepts only Normal or Stall.
- Hazard outputs are combinational from state and inputs. They take effect at the next rising edge of the pipeline registers.
- State register: RUN, MEM_WAIT, ERROR, 2 bits.
- Reset:
  - state=RUN, wait_cnt=0, stall_count=0, timeout_err=0.
  - While reset=1, all hazard outputs are Normal.
- RUN priority, highest first. One action per cycle; default is all Normal.
  1. mem_req && !mem_ready:
     - PC, IF_ID, ID_EX, EX_MEM = Stall; MEM_WB = Flush (bubble to WB).
     - Next state MEM_WAIT, wait_cnt=1.
     - Branch, jump and load-use are ignored this cycle. Their instructions are held and re-evaluated later.
  2. EX_branch_taken:
     - IF_ID = Flush, ID_EX = Flush; PC, EX_MEM, MEM_WB = Normal (PC loads the target).
  3. ID_jump:
     - IF_ID = Flush; all others Normal.
  4. Load-use: ID_EX_MemRead && ID_EX_rd!=0 && (ID_EX_rd==ID_rs || (ID_uses_rt && ID_EX_rd==ID_rt)):
     - PC = Stall, IF_ID = Stall, ID_EX = Flush; EX_MEM, MEM_WB = Normal.
     - Exactly one bubble, because the next cycle's EX holds the bubble.
- Register $0 never causes a load-use stall.
- MEM_WAIT:
  - mem_ready=0:
    - Outputs as RUN case 1.
    - wait_cnt increments.
    - If wait_cnt==TIMEOUT-1 at the edge, next state ERROR.
  - mem_ready=1:
    - The access completes and the pipeline advances.
    - Outputs are the RUN priorities 2–4 evaluated this cycle; mem_req is ignored.
    - Next state RUN, wait_cnt=0.
  - mem_ready=1 in the same cycle wait_cnt reaches TIMEOUT-1: ready wins, next state RUN.
- ERROR:
  - PC, IF_ID, ID_EX, EX_MEM = Stall; MEM_WB = Flush.
  - timeout_err=1, sticky. Only reset exits.
- stall_count:
  - Increments at each edge where hazard_PC==Stall (not during reset).
  - Saturates at 2^CNT_W−1; never wraps.
- Reset mid-MEM_WAIT or in ERROR: RUN next cycle, counters cleared.
- mem_ready in RUN without a stall pending (single-cycle access, mem_req && mem_ready) is treated as no memory hazard.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_rd=5, ID_rs=5 → one cycle of PC=10, IF_ID=10, ID_EX=01; next cycle (MemRead=0) all 00; stall_count=1. Repeat with ID_EX_rd=0 → no stall.
- rt qualifier: rd=7, ID_rt=7, ID_uses_rt=0 → all 00; ID_uses_rt=1 → stall as above.
- Taken branch together with load-use match → IF_ID=01, ID_EX=01, PC=00 (branch wins); ID_jump alone → only IF_ID=01.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready with EX_branch_taken=1 → 3 cycles of stall codes with MEM_WB=01, then IF_ID=ID_EX=01, PC=00; state RUN; stall_count=3.
- Timeout: TIMEOUT=8, mem_ready held 0 → ERROR entered after 8 wait cycles, timeout_err=1 and stays 1; synchronous reset → timeout_err=0, all outputs 00, stall_count=0. Ready on cycle 8 exactly → RUN, no error.
- Saturation: CNT_W=4, 20 stall cycles → stall_count=15 held.
